qam64_symbol_mapper: RTL and testbench

Downstream consumer of the 64-QAM modulator's synchronous FIFO. Pulls bytes from the FIFO read side in first-word-fall-through fashion and regroups them MSB-first into 6-bit symbols (4 symbols per 3 bytes). Maps each symbol to Gray-coded I/Q amplitude levels and presents them on a valid/ready output to the pulse-shaping stage.

---
 rtl/qam64_pkg.sv | 45 ++++
 rtl/qam64_gray_level_map.sv | 29 ++
 rtl/qam64_symbol_mapper.sv | 116 +++++++++++
 tb/tb_qam64_symbol_mapper.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam64_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qam64_pkg
// Purpose  : Shared constants and Gray-code-to-amplitude helper for the
//            64-QAM symbol mapper.
// Revision : 1.0 - initial release
// ============================================================================
package qam64_pkg;

    localparam int QAM_BITS  = 6;
    localparam int AXIS_BITS = 3;
    localparam int BUF_BITS  = 14;
    localparam int BYTE_BITS = 8;
    localparam int CNT_BITS  = 4;
    localparam int LVL_BITS  = 4;

    localparam logic signed [LVL_BITS-1:0] c_LVL_M7 = -4'sd7;
    localparam logic signed [LVL_BITS-1:0] c_LVL_M5 = -4'sd5;
    localparam logic signed [LVL_BITS-1:0] c_LVL_M3 = -4'sd3;
    localparam logic signed [LVL_BITS-1:0] c_LVL_M1 = -4'sd1;
    localparam logic signed [LVL_BITS-1:0] c_LVL_P1 = 4'sd1;
    localparam logic signed [LVL_BITS-1:0] c_LVL_P3 = 4'sd3;
    localparam logic signed [LVL_BITS-1:0] c_LVL_P5 = 4'sd5;
    localparam logic signed [LVL_BITS-1:0] c_LVL_P7 = 4'sd7;

    // Adjacent amplitude levels differ in exactly one code bit.
    function automatic logic signed [LVL_BITS-1:0] gray_to_level(
        input logic [AXIS_BITS-1:0] gray
    );
        logic signed [LVL_BITS-1:0] lvl;
        case (gray)
            3'b000:  lvl = c_LVL_M7;
            3'b001:  lvl = c_LVL_M5;
            3'b011:  lvl = c_LVL_M3;
            3'b010:  lvl = c_LVL_M1;
            3'b110:  lvl = c_LVL_P1;
            3'b111:  lvl = c_LVL_P3;
            3'b101:  lvl = c_LVL_P5;
            default: lvl = c_LVL_P7;
        endcase
        return lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qam64_gray_level_map.sv
`default_nettype none
// ============================================================================
// Module   : qam64_gray_level_map
// Purpose  : Combinational 3-bit Gray code to sign-extended amplitude level.
// Revision : 1.0 - initial release
// ============================================================================
module qam64_gray_level_map
    import qam64_pkg::*;
#(
    parameter int AMP_WIDTH = 4
) (
    input  logic [AXIS_BITS-1:0] i_gray,
    output logic [AMP_WIDTH-1:0] o_level
);

    logic signed [LVL_BITS-1:0] w_level;

    assign w_level = gray_to_level(i_gray);

    generate
        if (AMP_WIDTH > LVL_BITS) begin : g_sign_extend
            assign o_level = {{(AMP_WIDTH-LVL_BITS){w_level[LVL_BITS-1]}}, w_level};
        end else begin : g_native_width
            assign o_level = w_level;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/qam64_symbol_mapper.sv
`default_nettype none
// ============================================================================
// Module   : qam64_symbol_mapper
// Purpose  : Regroups FWFT FIFO bytes MSB-first into 6-bit symbols and maps
//            them to Gray-coded I/Q levels on a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module qam64_symbol_mapper
    import qam64_pkg::*;
#(
    parameter int AMP_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [7:0]           fifo_data,
    output logic                 fifo_rd_en,
    output logic [AMP_WIDTH-1:0] sym_i,
    output logic [AMP_WIDTH-1:0] sym_q,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic [15:0]          symbol_count
);

    localparam logic [CNT_BITS-1:0] c_CNT_SYM  = CNT_BITS'(QAM_BITS);
    localparam logic [CNT_BITS-1:0] c_CNT_BYTE = CNT_BITS'(BYTE_BITS);
    localparam logic [CNT_BITS-1:0] c_CNT_MAX  = CNT_BITS'(BUF_BITS);

    logic [BUF_BITS-1:0]  r_buf_q;
    logic [BUF_BITS-1:0]  w_buf_d;
    logic [BUF_BITS-1:0]  w_buf_post;
    logic [BUF_BITS-1:0]  w_byte_aligned;
    logic [CNT_BITS-1:0]  r_cnt_q;
    logic [CNT_BITS-1:0]  w_cnt_d;
    logic [CNT_BITS-1:0]  w_cnt_post;
    logic                 w_emit;
    logic                 w_rd;

    logic [AMP_WIDTH-1:0] w_lvl_i;
    logic [AMP_WIDTH-1:0] w_lvl_q;
    logic [AMP_WIDTH-1:0] r_sym_i_q;
    logic [AMP_WIDTH-1:0] w_sym_i_d;
    logic [AMP_WIDTH-1:0] r_sym_q_q;
    logic [AMP_WIDTH-1:0] w_sym_q_d;
    logic                 r_sym_valid_q;
    logic                 w_sym_valid_d;
    logic [15:0]          r_count_q;
    logic [15:0]          w_count_d;

    // Oldest buffered symbol is always at the top of the left-justified buffer.
    qam64_gray_level_map #(
        .AMP_WIDTH (AMP_WIDTH)
    ) u_map_i (
        .i_gray  (r_buf_q[BUF_BITS-1 -: AXIS_BITS]),
        .o_level (w_lvl_i)
    );

    qam64_gray_level_map #(
        .AMP_WIDTH (AMP_WIDTH)
    ) u_map_q (
        .i_gray  (r_buf_q[BUF_BITS-1-AXIS_BITS -: AXIS_BITS]),
        .o_level (w_lvl_q)
    );

    always_comb begin
        w_emit     = (r_cnt_q >= c_CNT_SYM) && (!r_sym_valid_q || sym_ready);
        w_cnt_post = w_emit ? (r_cnt_q - c_CNT_SYM) : r_cnt_q;
        w_buf_post = w_emit ? (r_buf_q << QAM_BITS) : r_buf_q;

        // Gated by rst so no byte is consumed while the datapath is held in reset.
        w_rd = !rst && !fifo_empty && (w_cnt_post <= c_CNT_SYM);

        // New byte lands directly beneath the bits still waiting in the buffer.
        w_byte_aligned = {fifo_data, {(BUF_BITS-BYTE_BITS){1'b0}}} >> w_cnt_post;

        w_buf_d = w_rd ? (w_buf_post | w_byte_aligned) : w_buf_post;
        w_cnt_d = w_rd ? (w_cnt_post + c_CNT_BYTE) : w_cnt_post;

        w_sym_i_d     = w_emit ? w_lvl_i : r_sym_i_q;
        w_sym_q_d     = w_emit ? w_lvl_q : r_sym_q_q;
        w_sym_valid_d = w_emit ? 1'b1 : (sym_ready ? 1'b0 : r_sym_valid_q);

        w_count_d = (r_sym_valid_q && sym_ready) ? (r_count_q + 16'd1) : r_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_q       <= '0;
            r_cnt_q       <= '0;
            r_sym_i_q     <= '0;
            r_sym_q_q     <= '0;
            r_sym_valid_q <= 1'b0;
            r_count_q     <= '0;
        end else begin
            r_buf_q       <= w_buf_d;
            r_cnt_q       <= w_cnt_d;
            r_sym_i_q     <= w_sym_i_d;
            r_sym_q_q     <= w_sym_q_d;
            r_sym_valid_q <= w_sym_valid_d;
            r_count_q     <= w_count_d;
        end
    end

    assign fifo_rd_en   = w_rd;
    assign sym_i        = r_sym_i_q;
    assign sym_q        = r_sym_q_q;
    assign sym_valid    = r_sym_valid_q;
    assign symbol_count = r_count_q;

`ifndef SYNTHESIS
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) r_cnt_q <= c_CNT_MAX);
    a_no_rd_when_empty: assert property (@(posedge clk) disable iff (rst) !(fifo_rd_en && fifo_empty));
`endif

endmodule
`default_nettype wire

// File: tb/tb_qam64_symbol_mapper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_qam64_symbol_mapper
// Purpose  : Self-checking bench with a bit-queue reference model and
//            directed byte streams for qam64_symbol_mapper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qam64_symbol_mapper;

    localparam int AMP_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 fifo_empty = 1'b1;
    logic [7:0]           fifo_data = 8'h00;
    logic                 fifo_rd_en;
    logic [AMP_WIDTH-1:0] sym_i;
    logic [AMP_WIDTH-1:0] sym_q;
    logic                 sym_valid;
    logic                 sym_ready = 1'b1;
    logic [15:0]          symbol_count;

    always #5 clk = ~clk;

    qam64_symbol_mapper #(
        .AMP_WIDTH (AMP_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd_en   (fifo_rd_en),
        .sym_i        (sym_i),
        .sym_q        (sym_q),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .symbol_count (symbol_count)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]             fifo_q[$];
    bit                     bit_q[$];
    logic [2*AMP_WIDTH-1:0] exp_q[$];
    logic [2*AMP_WIDTH-1:0] acc_q[$];
    logic [15:0]            model_count = 16'd0;
    int                     rd_total = 0;
    int                     tp_gaps = 0;
    bit                     tp_mode = 1'b0;

    // Gray code decodes to a binary rank 0..7; the level is 2*rank - 7.
    function automatic logic [AMP_WIDTH-1:0] model_level(input logic [2:0] g);
        int rank;
        rank = int'(g[2]) * 4 + int'(g[2] ^ g[1]) * 2 + int'(g[2] ^ g[1] ^ g[0]);
        return AMP_WIDTH'(2 * rank - 7);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor and compare process: sample at negedge, act on what the next posedge does.
    int                     cyc = 0;
    int                     rd_cyc = 0;
    bit                     seen_rd = 1'b0;
    bit                     seen_valid = 1'b0;
    bit                     prev_stall = 1'b0;
    logic [AMP_WIDTH-1:0]   prev_i = '0;
    logic [AMP_WIDTH-1:0]   prev_q = '0;

    always @(negedge clk) begin : mon
        logic [5:0]             s;
        logic [2*AMP_WIDTH-1:0] e;
        cyc++;
        if (rst) begin
            chk("rst_valid", sym_valid, 0);
            chk("rst_i", sym_i, 0);
            chk("rst_q", sym_q, 0);
            chk("rst_count", symbol_count, 0);
            chk("rst_rd_en", fifo_rd_en, 0);
            fifo_q.delete();
            bit_q.delete();
            exp_q.delete();
            model_count = 16'd0;
            seen_rd = 1'b0;
            seen_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", sym_valid, 1);
                chk("hold_i", sym_i, prev_i);
                chk("hold_q", sym_q, prev_q);
            end
            chk("rd_when_empty", fifo_rd_en && fifo_empty, 0);
            if (fifo_rd_en && !fifo_empty) begin
                for (int k = 7; k >= 0; k--) bit_q.push_back(fifo_data[k]);
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                rd_total++;
                if (!seen_rd) begin
                    seen_rd = 1'b1;
                    rd_cyc = cyc;
                end
                while (bit_q.size() >= 6) begin
                    for (int k = 5; k >= 0; k--) s[k] = bit_q.pop_front();
                    exp_q.push_back({model_level(s[5:3]), model_level(s[2:0])});
                end
            end
            if (sym_valid && !seen_valid) begin
                seen_valid = 1'b1;
                chk("first_latency", cyc - rd_cyc, 2);
            end
            if (tp_mode && seen_valid && !sym_valid && model_count < 16'd400) tp_gaps++;
            chk("symbol_count", symbol_count, model_count);
            if (sym_valid && sym_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_symbol", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sym_i", sym_i, e[2*AMP_WIDTH-1:AMP_WIDTH]);
                    chk("sym_q", sym_q, e[AMP_WIDTH-1:0]);
                end
                acc_q.push_back({sym_i, sym_q});
                model_count = model_count + 16'd1;
            end
            prev_stall = sym_valid && !sym_ready;
            prev_i = sym_i;
            prev_q = sym_q;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !sym_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        if (n >= max_cycles) chk({name, "_drain_timeout"}, 1, 0);
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!sym_valid && n < max_cycles) begin
            tick();
            n++;
        end
        chk({name, "_valid_seen"}, sym_valid, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin : stim
        int r0;
        int n;
        logic [7:0] bp_bytes[6];
        bp_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("model_000", model_level(3'b000), 4'h9);
        chk("model_011", model_level(3'b011), 4'hD);
        chk("model_110", model_level(3'b110), 4'h1);
        chk("model_100", model_level(3'b100), 4'h7);

        // 0x82 0x08 0x20: four symbols 100000 -> (+7,-7)
        acc_q.delete();
        fifo_q.push_back(8'h82); fifo_q.push_back(8'h08); fifo_q.push_back(8'h20);
        drain("t1", 40);
        chk("t1_nsym", acc_q.size(), 4);
        for (int k = 0; k < 4 && k < acc_q.size(); k++) chk("t1_sym", acc_q[k], 8'h79);

        // 0x05 0x39 0x77: all eight levels
        acc_q.delete();
        fifo_q.push_back(8'h05); fifo_q.push_back(8'h39); fifo_q.push_back(8'h77);
        drain("t2", 40);
        chk("t2_nsym", acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            chk("t2_sym0", acc_q[0], 8'h9B);
            chk("t2_sym1", acc_q[1], 8'hFD);
            chk("t2_sym2", acc_q[2], 8'h75);
            chk("t2_sym3", acc_q[3], 8'h13);
        end

        // Starvation: 0xFF alone gives 111111 -> (+3,+3), 2 bits retained
        acc_q.delete();
        fifo_q.push_back(8'hFF);
        drain("starve1", 40);
        r0 = rd_total;
        repeat (10) tick();
        chk("starve_no_rd", rd_total - r0, 0);
        chk("starve_rd_en", fifo_rd_en, 0);
        chk("starve_nsym1", acc_q.size(), 1);
        if (acc_q.size() >= 1) chk("starve_sym0", acc_q[0], 8'h33);
        fifo_q.push_back(8'hFF);
        drain("starve2", 40);
        chk("starve_nsym2", acc_q.size(), 2);
        if (acc_q.size() >= 2) chk("starve_sym1", acc_q[1], 8'h33);

        // Reset mid-stream with a pending symbol; leftover bits must be discarded
        fifo_q.push_back(8'h05); fifo_q.push_back(8'h39); fifo_q.push_back(8'h77);
        fifo_q.push_back(8'h12); fifo_q.push_back(8'h34); fifo_q.push_back(8'h56);
        wait_valid("rst_mid", 20);
        do_reset();
        acc_q.delete();
        fifo_q.push_back(8'h05); fifo_q.push_back(8'h39); fifo_q.push_back(8'h77);
        drain("post_rst", 40);
        chk("post_rst_nsym", acc_q.size(), 4);
        if (acc_q.size() >= 1) chk("post_rst_sym0", acc_q[0], 8'h9B);

        // Backpressure: 5 stalled cycles mid-stream
        acc_q.delete();
        for (int k = 0; k < 6; k++) fifo_q.push_back(bp_bytes[k]);
        wait_valid("bp", 20);
        sym_ready = 1'b0;
        r0 = rd_total;
        repeat (5) tick();
        chk("bp_reads_le2", (rd_total - r0) <= 2, 1);
        chk("bp_rd_en_low", fifo_rd_en, 0);
        chk("bp_valid_held", sym_valid, 1);
        sym_ready = 1'b1;
        drain("bp", 60);
        chk("bp_nsym", acc_q.size(), 8);
        if (acc_q.size() >= 4) begin
            chk("bp_sym0", acc_q[0], 8'h97);
            chk("bp_sym1", acc_q[1], 8'h7D);
            chk("bp_sym2", acc_q[2], 8'hFB);
            chk("bp_sym3", acc_q[3], 8'hF1);
        end

        // Throughput: 300 random bytes -> 400 back-to-back symbols
        do_reset();
        tp_mode = 1'b1;
        tp_gaps = 0;
        for (int k = 0; k < 300; k++) fifo_q.push_back(8'($urandom_range(0, 255)));
        n = 0;
        while (model_count < 16'd400 && n < 1000) begin
            tick();
            n++;
        end
        chk("tp_model_count", model_count, 400);
        chk("tp_cycles_le404", n <= 404, 1);
        chk("tp_symbol_count", symbol_count, 400);
        chk("tp_no_gaps", tp_gaps, 0);
        tp_mode = 1'b0;
        drain("tp", 20);
        chk("tp_exp_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
